shared_timer_arbiter: RTL and testbench

//  Shares one 16-bit up-counter (timer_cnt) among N_REQ requesters that each need a timed delay.
//  - Round-robin arbitration picks one requester.
//  - The counter then times that requester's programmed length.
//  - The requester gets a one-cycle done pulse at the end.

---
 rtl/shared_timer_arbiter_pkg.sv | 40 ++++
 rtl/shared_timer_arbiter_cnt.sv | 36 +++
 rtl/shared_timer_arbiter.sv | 147 ++++++++++++++
 tb/tb_shared_timer_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_timer_arbiter_pkg.sv
// Purpose : shared types, constants and the round-robin helper for the
//           shared timer arbiter.
// Contents: state_t      - FSM encoding (IDLE, RUN, DONE)
//           WIDTH_DEF    - default counter / length width
//           MAX_REQ      - widest requester vector the helper handles
//           rr_pick()    - first requester at or after a pointer, one-hot
package timer_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int MAX_REQ   = 8;
  localparam int PTR_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Scans the 8 possible positions starting at ptr and wrapping. Callers
  // zero-pad unused request bits above N_REQ. Because ptr is always below
  // N_REQ, the padding never wins. The scan therefore wraps as if it were
  // modulo N_REQ.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [PTR_W-1:0]   ptr);
    logic [MAX_REQ-1:0] pick;
    logic               found;
    logic [PTR_W-1:0]   idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = ptr + PTR_W'(k);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/shared_timer_arbiter_cnt.sv
// Purpose : WIDTH-bit up-counter shared by all requesters.
// Ports   : clk     - clock, rising edge
//           reset_n - asynchronous active-low reset
//           clr     - synchronous clear, has priority over en
//           en      - increment enable
//           q       - current count
module timer_cnt
  import timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;

  // Counter register: clear beats increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/shared_timer_arbiter.sv
// Purpose : shares one up-counter among N_REQ requesters. Round-robin
//           arbitration picks an owner. The counter then times that owner's
//           latched length. A one-cycle done pulse marks the end.
// Ports   : clk     - clock, rising edge
//           reset_n - asynchronous active-low reset
//           req     - level request per requester
//           len     - per-requester delay length, slice i = len[i*WIDTH +: WIDTH]
//           gnt     - one-hot grant, high during every RUN cycle of the owner
//           done    - one-cycle completion pulse to the owner
//           busy    - high in RUN and DONE
//           cnt_q   - live counter value
module shared_timer_arbiter
  import timer_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] len,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [WIDTH-1:0]       cnt_q
);

  localparam logic [WIDTH-1:0] LEN_ONE = WIDTH'(1);

  state_t             state_q;
  logic [PTR_W-1:0]   rr_q;
  logic [PTR_W-1:0]   owner_q;
  logic [WIDTH-1:0]   len_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   done_q;
  logic               busy_q;

  logic [MAX_REQ-1:0] req_pad_s;
  logic [MAX_REQ-1:0] pick_s;
  logic [PTR_W-1:0]   pick_idx_s;
  logic [WIDTH-1:0]   len_sel_s;
  logic [PTR_W-1:0]   rr_next_s;
  logic               run_end_s;
  logic               abort_s;
  logic               cnt_clr_s;
  logic               cnt_en_s;
  logic [WIDTH-1:0]   cnt_s;

  // Arbitration and run-termination decisions, evaluated every cycle.
  always_comb begin
    req_pad_s              = '0;
    req_pad_s[N_REQ-1:0]   = req;
    pick_s                 = rr_pick(req_pad_s, rr_q);
    pick_idx_s             = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (pick_s[k]) begin
        pick_idx_s = PTR_W'(k);
      end else begin
        pick_idx_s = pick_idx_s;
      end
    end
    len_sel_s = len[pick_idx_s*WIDTH +: WIDTH];
    if (owner_q == PTR_W'(N_REQ - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = owner_q + PTR_W'(1);
    end
    // Abort wins over completion when the owner drops req on its last cycle.
    abort_s   = (state_q == ST_RUN) && !req_pad_s[owner_q];
    run_end_s = (state_q == ST_RUN) && req_pad_s[owner_q] && (cnt_s == len_q - LEN_ONE);
    // The counter reads 0 on the first RUN cycle because it is held clear elsewhere.
    cnt_en_s  = (state_q == ST_RUN);
    cnt_clr_s = (state_q != ST_RUN) || run_end_s || abort_s;
  end

  // Arbiter FSM with registered grant/done/busy outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      len_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= '0;
          if (|req) begin
            state_q <= ST_RUN;
            owner_q <= pick_idx_s;
            // A zero length still times one cycle.
            len_q   <= (len_sel_s == '0) ? LEN_ONE : len_sel_s;
            gnt_q   <= pick_s[N_REQ-1:0];
            busy_q  <= 1'b1;
          end else begin
            gnt_q  <= '0;
            busy_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abort_s) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            rr_q    <= rr_next_s;
          end else if (run_end_s) begin
            state_q <= ST_DONE;
            gnt_q   <= '0;
            done_q  <= gnt_q;
            rr_q    <= rr_next_s;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  timer_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr_s),
    .en      (cnt_en_s),
    .q       (cnt_s)
  );

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign cnt_q = cnt_s;

endmodule

// File: tb/tb_shared_timer_arbiter.sv
module tb_shared_timer_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [63:0] len;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [15:0] cnt_q;

  int errors;
  int checks;

  shared_timer_arbiter #(.N_REQ(4), .WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .len     (len),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .cnt_q   (cnt_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req     = 4'b0000;
    len     = 64'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = 4'b0001;
    len     = 64'd3;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, done, busy, cnt_q} !== {4'b0000, 4'b0000, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_values: gnt=%b done=%b busy=%b cnt=%h, want all zero", gnt, done, busy, cnt_q);
    end
    req     = 4'b0000;
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    len[15:0] = 16'd5;
    req       = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({gnt, done, busy, cnt_q} !== {4'b0001, 4'b0000, 1'b1, 16'(i)}) begin
        errors++;
        $display("FAIL single_run%0d: gnt=%b done=%b busy=%b cnt=%h, want 0001 0000 1 %h", i, gnt, done, busy, cnt_q, 16'(i));
      end
      // Length changes after the grant must not shorten the run.
      if (i == 1) len[15:0] = 16'd2;
    end
    @(negedge clk);
    checks++;
    if ({gnt, done, busy, cnt_q} !== {4'b0000, 4'b0001, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL single_done: gnt=%b done=%b busy=%b cnt=%h, want 0000 0001 1 0000", gnt, done, busy, cnt_q);
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if ({gnt, done, busy, cnt_q} !== {4'b0000, 4'b0000, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL single_idle: gnt=%b done=%b busy=%b cnt=%h, want all zero", gnt, done, busy, cnt_q);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp;
    do_reset();
    len = {4{16'd2}};
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp = 4'b0001 << (g % 4);
      @(negedge clk);
      checks++;
      if ({gnt, done, busy, cnt_q} !== {exp, 4'b0000, 1'b1, 16'd0}) begin
        errors++;
        $display("FAIL rot%0d_run0: gnt=%b done=%b busy=%b cnt=%h, want %b 0000 1 0000", g, gnt, done, busy, cnt_q, exp);
      end
      @(negedge clk);
      checks++;
      if ({gnt, done, busy, cnt_q} !== {exp, 4'b0000, 1'b1, 16'd1}) begin
        errors++;
        $display("FAIL rot%0d_run1: gnt=%b done=%b busy=%b cnt=%h, want %b 0000 1 0001", g, gnt, done, busy, cnt_q, exp);
      end
      @(negedge clk);
      checks++;
      if ({gnt, done, busy, cnt_q} !== {4'b0000, exp, 1'b1, 16'd0}) begin
        errors++;
        $display("FAIL rot%0d_done: gnt=%b done=%b busy=%b cnt=%h, want 0000 %b 1 0000", g, gnt, done, busy, cnt_q, exp);
      end
      if (g == 4) req = 4'b0000;
      @(negedge clk);
      checks++;
      if ({gnt, done, busy, cnt_q} !== {4'b0000, 4'b0000, 1'b0, 16'd0}) begin
        errors++;
        $display("FAIL rot%0d_gap: gnt=%b done=%b busy=%b cnt=%h, want all zero", g, gnt, done, busy, cnt_q);
      end
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    len[31:16] = 16'd0;
    req        = 4'b0010;
    @(negedge clk);
    checks++;
    if ({gnt, done, busy, cnt_q} !== {4'b0010, 4'b0000, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL zero_run: gnt=%b done=%b busy=%b cnt=%h, want 0010 0000 1 0000", gnt, done, busy, cnt_q);
    end
    @(negedge clk);
    checks++;
    if ({gnt, done, busy, cnt_q} !== {4'b0000, 4'b0010, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL zero_done: gnt=%b done=%b busy=%b cnt=%h, want 0000 0010 1 0000", gnt, done, busy, cnt_q);
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if ({gnt, done, busy} !== {4'b0000, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL zero_idle: gnt=%b done=%b busy=%b, want 0000 0000 0", gnt, done, busy);
    end
  endtask

  task automatic test_abort();
    do_reset();
    len[47:32] = 16'd10;
    len[63:48] = 16'd3;
    req        = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({gnt, done, busy, cnt_q} !== {4'b0100, 4'b0000, 1'b1, 16'(i)}) begin
        errors++;
        $display("FAIL abort_run%0d: gnt=%b done=%b busy=%b cnt=%h, want 0100 0000 1 %h", i, gnt, done, busy, cnt_q, 16'(i));
      end
    end
    req = 4'b1000;
    @(negedge clk);
    checks++;
    if ({gnt, done, busy, cnt_q} !== {4'b0000, 4'b0000, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL abort_idle: gnt=%b done=%b busy=%b cnt=%h, want all zero", gnt, done, busy, cnt_q);
    end
    @(negedge clk);
    checks++;
    if ({gnt, done, busy, cnt_q} !== {4'b1000, 4'b0000, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL abort_next: gnt=%b done=%b busy=%b cnt=%h, want 1000 0000 1 0000", gnt, done, busy, cnt_q);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    len[15:0] = 16'd100;
    req       = 4'b0001;
    repeat (41) @(negedge clk);
    checks++;
    if ({gnt, cnt_q} !== {4'b0001, 16'd40}) begin
      errors++;
      $display("FAIL midrst_pre: gnt=%b cnt=%h, want 0001 0028", gnt, cnt_q);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({gnt, done, busy, cnt_q} !== {4'b0000, 4'b0000, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL midrst_async: gnt=%b done=%b busy=%b cnt=%h, want all zero", gnt, done, busy, cnt_q);
    end
    @(negedge clk);
    req     = 4'b0011;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt, done, busy, cnt_q} !== {4'b0001, 4'b0000, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL midrst_regrant: gnt=%b done=%b busy=%b cnt=%h, want 0001 0000 1 0000", gnt, done, busy, cnt_q);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_max_len();
    int bad;
    do_reset();
    len[15:0] = 16'hFFFF;
    req       = 4'b0001;
    bad       = 0;
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk);
      if ({gnt, done, cnt_q} !== {4'b0001, 4'b0000, 16'(i)}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL max_run: %0d bad RUN cycles, want 0", bad);
    end
    checks++;
    if (cnt_q !== 16'hFFFE) begin
      errors++;
      $display("FAIL max_last_cnt: cnt=%h, want fffe", cnt_q);
    end
    @(negedge clk);
    checks++;
    if ({gnt, done, busy, cnt_q} !== {4'b0000, 4'b0001, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL max_done: gnt=%b done=%b busy=%b cnt=%h, want 0000 0001 1 0000", gnt, done, busy, cnt_q);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    req     = 4'b0000;
    len     = 64'd0;
    test_reset();
    test_single();
    test_rotation();
    test_zero_len();
    test_abort();
    test_reset_mid_run();
    test_max_len();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
